// File: rtl/emin_dp_argmin.sv
// Min-plus reduction for one DP layer: D(k,i) = min_j [D(k-1,j-1) + max(E_min(j,i),0)].
// The result also gives the argmin j. The datapath accepts one term per cycle and uses a 2-cycle registered BRAM lookup.
module emin_dp_argmin #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  localparam int IW       = $clog2(I)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_valid,
  input  logic [IW-1:0]               i_in,
  input  logic                        first_layer,
  input  logic                        emin_valid,
  input  logic [IW-1:0]               j_in,
  input  logic signed [BIT_WIDTH-1:0] emin_in,
  output logic [IW-1:0]               prev_req,
  input  logic signed [BIT_WIDTH-1:0] prev_resp,
  output logic signed [BIT_WIDTH-1:0] cost_out,
  output logic [IW-1:0]               argmin_out,
  output logic [IW-1:0]               i_out,
  output logic                        output_valid,
  output logic                        busy
);

  localparam logic signed [BIT_WIDTH-1:0] MAXPOS = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_next;

  logic [IW-1:0] i_lat;
  logic          first_lat;
  logic          last_taken;

  logic                        s1_valid, s2_valid, s3_valid;
  logic [IW-1:0]               s1_j, s2_j, s3_j;
  logic signed [BIT_WIDTH-1:0] s1_e, s2_e, s3_sum;

  logic signed [BIT_WIDTH-1:0] run_min;
  logic [IW-1:0]               run_arg;

  logic                        accept, enter, final_hit, better;
  logic signed [BIT_WIDTH-1:0] e_clamp, p_val, sum_sat, term;
  logic signed [BIT_WIDTH:0]   sum_wide;
  logic                        feasible;

  always_comb begin
    state_next = state;
    enter      = 1'b0;
    accept     = 1'b0;
    final_hit  = 1'b0;
    better     = 1'b0;
    if (state == IDLE) begin
      if (start_valid) begin
        enter      = 1'b1;
        state_next = ACCUM;
      end
    end else begin
      accept    = emin_valid && !last_taken && (j_in <= i_lat);
      better    = s3_valid && (s3_sum < run_min);
      final_hit = s3_valid && (s3_j == i_lat);
      if (final_hit) state_next = IDLE;
    end
  end

  // Term formation: clamp negative E_min, saturate the add, then apply layer feasibility.
  always_comb begin
    e_clamp  = s2_e[BIT_WIDTH-1] ? '0 : s2_e;
    p_val    = (s2_j == '0) ? '0 : prev_resp;
    sum_wide = {p_val[BIT_WIDTH-1], p_val} + {1'b0, e_clamp};
    sum_sat  = (sum_wide[BIT_WIDTH] != sum_wide[BIT_WIDTH-1]) ? MAXPOS : sum_wide[BIT_WIDTH-1:0];
    if (first_lat) feasible = (s2_j == '0);
    else           feasible = (s2_j != '0) && (prev_resp != MAXPOS);
    term = feasible ? sum_sat : MAXPOS;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      i_lat      <= '0;
      first_lat  <= 1'b0;
      last_taken <= 1'b0;
    end else begin
      state <= state_next;
      if (enter) begin
        i_lat      <= i_in;
        first_lat  <= first_layer;
        last_taken <= 1'b0;
      end else if (accept && (j_in == i_lat)) begin
        last_taken <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_req <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_j     <= '0;
      s2_j     <= '0;
      s3_j     <= '0;
      s1_e     <= '0;
      s2_e     <= '0;
      s3_sum   <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (accept) begin
        prev_req <= (j_in == '0) ? '0 : j_in - IW'(1);
        s1_j     <= j_in;
        s1_e     <= emin_in;
      end
      s2_j   <= s1_j;
      s2_e   <= s1_e;
      s3_j   <= s2_j;
      s3_sum <= term;
    end
  end

  // The final term is folded in combinationally so the result is registered on the j==i cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_min      <= MAXPOS;
      run_arg      <= '0;
      cost_out     <= '0;
      argmin_out   <= '0;
      i_out        <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= final_hit;
      if (enter) begin
        run_min <= MAXPOS;
        run_arg <= '0;
      end else if (better) begin
        run_min <= s3_sum;
        run_arg <= s3_j;
      end
      if (final_hit) begin
        cost_out   <= better ? s3_sum : run_min;
        argmin_out <= better ? s3_j : run_arg;
        i_out      <= i_lat;
      end
    end
  end

  assign busy = (state == ACCUM);

endmodule
